sync_down_counter: RTL and testbench
====================================

# sync_down_counter

Synchronous, loadable, parameterised down counter and timer. It is the counterpart to the team's asynchronous ripple up counter: it counts down from a loaded value instead of up from zero. Every flop is clocked by the single system clock. It supports one-shot and periodic (auto-reload) modes and produces a registered terminal-count pulse. It serves as the programmable delay and tick generator for downstream control logic.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset, synchronous, active-high
- load  input  1  load request; loads `load_val` and samples `mode`
- load_val  input  WIDTH  start/reload value
- mode  input  1  0 = one-shot, 1 = periodic; sampled only on `load`
- en  input  1  count enable; ignored in IDLE and DONE
- q  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  high while the block is in RUN
- done  output  1  high in DONE (one-shot finished)

## Operation
- Internal registers: `reload` (WIDTH bits) and `mode_r` (1 bit), both written only on `load`.
- Priority on every edge: `rst` > `load` > `en`.
- **Reset** sets q=0, reload=0, mode_r=0, tc=0, busy=0, done=0, state=IDLE.
  - Reset asserted mid-run aborts immediately. No tc is issued.
- **FSM states:**
  - IDLE: q holds its value, busy=0, done=0.
  - RUN: busy=1.
  - DONE: q=0, done=1.
- **load=1, in any state:**
  - q←load_val, reload←load_val, mode_r←mode, tc←0.
  - If load_val≠0, state→RUN. If load_val=0, state→IDLE and no tc is issued.
- **RUN with en=1:**
  - q>1: q←q−1.
  - q==1 and mode_r=0: q←0, tc←1, state→DONE.
  - q==1 and mode_r=1: q←reload, tc←1, state stays RUN.
- **RUN with en=0:** q holds, tc←0.
- **DONE:** en is ignored. Only load or rst leaves DONE.
- **Cycle counts:**
  - Periodic mode with reload value N: exactly one tc per N enabled cycles.
  - One-shot mode with value N: tc occurs N enabled cycles after load.
- **Arithmetic:**
  - Unsigned arithmetic throughout; no underflow is possible because q never decrements from 0.
  - Maximum load is 2^WIDTH−1.
- **tc** is cleared on every edge where it is not being set, so it is never high on two consecutive cycles.
  - Exception: periodic mode with reload=1 gives tc high every enabled cycle.

## Timing
- load → q shows load_val on the next edge (1-cycle latency). busy and done update on the same edge.
- tc rises on the same edge that q becomes 0 (one-shot) or becomes reload (periodic). It falls on the following edge.
- en is a level signal. Decrement is visible on the edge after the cycle in which en is sampled high.
- All outputs come directly from flops; there are no combinational input-to-output paths.
- load together with the final decrement: load wins, tc=0, and no DONE transition occurs.

## Structure
- Shared package `counter_pkg`:
  - state enum {IDLE, RUN, DONE}
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
- One sub-module, `dcnt_core`: the WIDTH-bit register with synchronous clear, load and decrement-enable, and a `q_is_one` flag output.
- The top level holds the FSM, the reload and mode registers, and tc, busy and done.

## Test plan
- **Reset:** drive random inputs, then assert rst for 2 cycles. Expect q=0, tc=0, busy=0, done=0. Counting must not resume after rst falls until a load occurs.
- **One-shot:** load_val=3, mode=0, en=1 held. Expect q sequence 3,2,1,0. Expect tc high only on the cycle q=0. Expect done=1 and busy=0 from then on, with q held at 0 for 10 further cycles.
- **Periodic:** load_val=4, mode=1, en=1. Expect q sequence 4,3,2,1,4,3,2,1,4. Expect tc high on each cycle q returns to 4, i.e. every 4 cycles. done stays 0.
- **Enable gaps:** load 5, then en pattern 1,0,0,1,1,1,1. Expect q sequence 5,4,4,4,3,2,1,0. Expect tc on the final cycle only.
- **Reload mid-run:** load_val=15 periodic; when q=2, load 9 in one-shot mode. Expect q=9 next cycle and no tc. Expect it to finish in DONE after 9 enabled cycles. Separately, load 0 → IDLE with no tc.
- **Collision:** assert rst and load(7) together while q=1 with en=1. Expect q=0, state IDLE, tc=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the synchronous down counter / timer.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cnt_state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/dcnt_core.sv
// WIDTH-bit count register: synchronous clear, load and decrement, plus a q==1 flag.
module dcnt_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             dec,
   output logic [WIDTH-1:0] q,
   output logic             q_is_one
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (ld) begin
         q <= ld_val;
      end else if (dec && (q != '0)) begin
         q <= q - 1'b1;
      end
   end

   assign q_is_one = (q == WIDTH'(1));

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter / timer with one-shot and periodic modes and a registered tc pulse.
//
//   state | meaning
//   IDLE  | no count in progress, q holds
//   RUN   | counting down on en, busy=1
//   DONE  | one-shot expired, q=0, done=1 until load or rst
module sync_down_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mode,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   cnt_state_t       state;
   logic [WIDTH-1:0] reload;
   logic             mode_r;
   logic             q_is_one;
   logic             run_step;
   logic             expire;
   logic             core_ld;
   logic [WIDTH-1:0] core_val;

   assign run_step = (state == RUN) && en;
   assign expire   = run_step && q_is_one;

   // Periodic expiry re-enters the count through the load path of the core.
   assign core_ld  = load || (expire && (mode_r == MODE_PERIODIC));
   assign core_val = load ? load_val : reload;

   dcnt_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .clr      (rst),
      .ld       (core_ld),
      .ld_val   (core_val),
      .dec      (run_step),
      .q        (q),
      .q_is_one (q_is_one)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         reload <= '0;
         mode_r <= MODE_ONESHOT;
         tc     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (load) begin
         reload <= load_val;
         mode_r <= mode;
         tc     <= 1'b0;
         done   <= 1'b0;
         if (load_val != '0) begin
            state <= RUN;
            busy  <= 1'b1;
         end else begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end else begin
         tc <= 1'b0;
         case (state)
            RUN: begin
               if (expire) begin
                  tc <= 1'b1;
                  if (mode_r == MODE_ONESHOT) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter (WIDTH=4).
module tb_sync_down_counter;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             mode;
   logic             en;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;
   logic             done;

   int checks   = 0;
   int failures = 0;

   sync_down_counter #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .en       (en),
      .q        (q),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int unsigned eq, input int unsigned etc,
                            input int unsigned ebusy, input int unsigned edone);
      check({tag, ".q"},    int'(q),    eq);
      check({tag, ".tc"},   int'(tc),   etc);
      check({tag, ".busy"}, int'(busy), ebusy);
      check({tag, ".done"}, int'(done), edone);
   endtask

   task automatic do_load(input int unsigned v, input logic m);
      load = 1'b1; load_val = WIDTH'(v); mode = m;
      tick();
      load = 1'b0;
   endtask

   initial begin
      int unsigned os_q[3]  = '{2, 1, 0};
      int unsigned os_tc[3] = '{0, 0, 1};
      int unsigned pq[8]    = '{3, 2, 1, 4, 3, 2, 1, 4};
      int unsigned ptc[8]   = '{0, 0, 0, 1, 0, 0, 0, 1};
      logic        gen[7]   = '{1, 0, 0, 1, 1, 1, 1};
      int unsigned gq[7]    = '{4, 4, 4, 3, 2, 1, 0};
      int unsigned gtc[7]   = '{0, 0, 0, 0, 0, 0, 1};
      int          budget;

      rst = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0; en = 1'b0;
      #1;

      // Reset after random activity
      for (int i = 0; i < 8; i++) begin
         load = 1'($urandom); load_val = WIDTH'($urandom);
         mode = 1'($urandom); en = 1'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      tick();
      check_all("reset", 0, 0, 0, 0);
      rst = 1'b0; load = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check_all("post_reset_idle", 0, 0, 0, 0);

      // One-shot from 3
      do_load(3, 1'b0);
      check_all("os_load", 3, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("os.q", int'(q), os_q[i]);
         check("os.tc", int'(tc), os_tc[i]);
      end
      check_all("os_done", 0, 1, 0, 1);
      for (int i = 0; i < 10; i++) tick();
      check_all("os_hold", 0, 0, 0, 1);

      // Periodic from 4
      do_load(4, 1'b1);
      check_all("per_load", 4, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("per.q", int'(q), pq[i]);
         check("per.tc", int'(tc), ptc[i]);
         check("per.done", int'(done), 0);
      end

      // Enable gaps, one-shot from 5
      do_load(5, 1'b0);
      check("gap_load.q", int'(q), 5);
      for (int i = 0; i < 7; i++) begin
         en = gen[i];
         tick();
         check("gap.q", int'(q), gq[i]);
         check("gap.tc", int'(tc), gtc[i]);
      end
      check("gap.done", int'(done), 1);
      en = 1'b1;

      // Reload mid-run: periodic 15, switch to one-shot 9 at q=2
      do_load(15, 1'b1);
      check("rl_load.q", int'(q), 15);
      budget = 40;
      while (q != WIDTH'(2) && budget > 0) begin
         tick();
         budget--;
      end
      check("rl_reach2", int'(q == WIDTH'(2)), 1);
      do_load(9, 1'b0);
      check_all("rl_new", 9, 0, 1, 0);
      for (int i = 0; i < 8; i++) tick();
      check_all("rl_pre", 1, 0, 1, 0);
      tick();
      check_all("rl_end", 0, 1, 0, 1);
      do_load(0, 1'b1);
      check_all("load_zero", 0, 0, 0, 0);
      tick();
      check_all("load_zero_hold", 0, 0, 0, 0);

      // Load coincident with final decrement: load wins
      do_load(2, 1'b0);
      tick();
      check("ldcol_q1", int'(q), 1);
      do_load(6, 1'b0);
      check_all("ldcol", 6, 0, 1, 0);

      // Periodic reload=1: tc every enabled cycle
      do_load(1, 1'b1);
      check_all("p1_load", 1, 0, 1, 0);
      tick();
      check_all("p1_a", 1, 1, 1, 0);
      tick();
      check_all("p1_b", 1, 1, 1, 0);

      // rst + load together at q=1 with en
      do_load(2, 1'b0);
      tick();
      check("col_q1", int'(q), 1);
      rst = 1'b1; load = 1'b1; load_val = WIDTH'(7); en = 1'b1;
      tick();
      rst = 1'b0; load = 1'b0;
      check_all("col", 0, 0, 0, 0);
      tick();
      check_all("col_idle", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
